// File: rtl/prog_seq_detector.sv
// Moore serial-pattern detector with a runtime-loadable pattern and selectable overlap.
// Define MATCH_CNT_EN to add the saturating hit counter (match_cnt, cnt_clr).
module prog_seq_detector #(
   parameter int unsigned      PAT_W       = 5,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = 5'b10101,
   parameter int unsigned      CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             overlap,
`ifdef MATCH_CNT_EN
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] match_cnt,
`endif
   output logic             match
);

   if (PAT_W < 2 || CNT_W < 1) begin : g_param_check
      $error("prog_seq_detector: PAT_W must be >= 2 and CNT_W >= 1");
   end

   localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   // Bit 0 of the encoding is the match output, so match comes straight off a flop.
   typedef enum logic [2:0] {
      EMPTY = 3'b000,
      FILL  = 3'b010,
      FULL  = 3'b100,
      HIT   = 3'b001
   } state_t;

   state_t              state;
   logic [PAT_W-1:0]    pat;
   logic [PAT_W-1:0]    hist;
   logic [FILL_W-1:0]   fill;

   logic [PAT_W-1:0]    hist_n;
   logic [FILL_W-1:0]   fill_n;
   logic                hit;

   function automatic state_t fill_state(input logic [FILL_W-1:0] f);
      if (f == '0)
         return EMPTY;
      else if (f == FILL_FULL)
         return FULL;
      else
         return FILL;
   endfunction

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      hist_n = {hist[PAT_W-2:0], din};
      fill_n = (fill == FILL_FULL) ? fill : fill + 1'b1;
      hit    = (fill_n == FILL_FULL) && (hist_n == pat);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat   <= PAT_DEFAULT;
         hist  <= '0;
         fill  <= '0;
         state <= EMPTY;
      end else if (pat_load) begin
         pat   <= pat_in;
         fill  <= '0;
         state <= EMPTY;
      end else if (en) begin
         hist <= hist_n;
         if (hit) begin
            // Non-overlapping mode discards the history so the next hit needs fresh bits.
            fill  <= overlap ? FILL_FULL : '0;
            state <= HIT;
         end else begin
            fill  <= fill_n;
            state <= fill_state(fill_n);
         end
      end else begin
         state <= fill_state(fill);
      end
   end

   assign match = state[0];

`ifdef MATCH_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_cnt <= '0;
      end else if (cnt_clr) begin
         match_cnt <= '0;
      end else if (en && !pat_load && hit && (match_cnt != '1)) begin
         match_cnt <= match_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_prog_seq_detector.sv
// Self-checking bench for prog_seq_detector: directed scenarios plus random traffic
// compared against a bit-queue reference model of the detection rules.
module tb_prog_seq_detector;

   localparam int               PAT_W   = 5;
   localparam logic [PAT_W-1:0] PAT_DEF = 5'b10101;

   logic             clk      = 1'b0;
   logic             rst      = 1'b0;
   logic             en       = 1'b0;
   logic             din      = 1'b0;
   logic             pat_load = 1'b0;
   logic [PAT_W-1:0] pat_in   = '0;
   logic             overlap  = 1'b0;
   logic             match;
`ifdef MATCH_CNT_EN
   logic             cnt_clr  = 1'b0;
   logic [7:0]       match_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: the valid bits received since the last reset, pattern load
   // or non-overlapping hit, oldest first, trimmed to the pattern length.
   bit               q[$];
   logic [PAT_W-1:0] m_pat   = PAT_DEF;
   logic             m_match = 1'b0;
   int               m_cnt   = 0;

   always #5 clk = ~clk;

   prog_seq_detector #(.PAT_W(PAT_W), .PAT_DEFAULT(PAT_DEF), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .din      (din),
      .pat_load (pat_load),
      .pat_in   (pat_in),
      .overlap  (overlap),
`ifdef MATCH_CNT_EN
      .cnt_clr  (cnt_clr),
      .match_cnt(match_cnt),
`endif
      .match    (match)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_pat   = PAT_DEF;
      m_match = 1'b0;
      m_cnt   = 0;
   endfunction

   function automatic void model_edge(input logic e, input logic d, input logic pl,
                                      input logic [PAT_W-1:0] pi, input logic ov,
                                      input logic clr);
      bit hit = 1'b0;
      if (pl) begin
         m_pat = pi;
         q.delete();
      end else if (e) begin
         q.push_back(d);
         if (q.size() > PAT_W) void'(q.pop_front());
         if (q.size() == PAT_W) begin
            hit = 1'b1;
            for (int i = 0; i < PAT_W; i++)
               if (q[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
         end
         if (hit && !ov) q.delete();
      end
      m_match = hit;
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < 255) m_cnt++;
   endfunction

   // Drives one edge's inputs at the falling edge, checks outputs at the next falling edge.
   task automatic step(input logic e, input logic d, input logic pl,
                       input logic [PAT_W-1:0] pi, input logic ov, input logic clr,
                       input string tag);
      en       = e;
      din      = d;
      pat_load = pl;
      pat_in   = pi;
      overlap  = ov;
`ifdef MATCH_CNT_EN
      cnt_clr  = clr;
`endif
      @(posedge clk);
      model_edge(e, d, pl, pi, ov, clr);
      @(negedge clk);
      check({tag, "_match"}, {31'd0, match}, {31'd0, m_match});
`ifdef MATCH_CNT_EN
      check({tag, "_cnt"}, {24'd0, match_cnt}, m_cnt);
`endif
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n, input logic ov, input string tag);
      for (int i = n - 1; i >= 0; i--)
         step(1'b1, bits[i], 1'b0, '0, ov, 1'b0, tag);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b0;
      model_reset();
      #1;
      check({tag, "_rst_match"}, {31'd0, match}, {31'd0, m_match});
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      model_reset();
      #2;
      check("reset_match", {31'd0, match}, 32'd0);
`ifdef MATCH_CNT_EN
      check("reset_cnt", {24'd0, match_cnt}, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b1;

      // Default pattern, non-overlapping, then one extra bit.
      send_bits(16'b10101, 5, 1'b0, "t1");
      send_bits(16'b0, 1, 1'b0, "t1_after");

      // Overlapping vs non-overlapping on 1010101.
      do_reset("t2a");
      send_bits(16'b1010101, 7, 1'b1, "t2_ov");
      do_reset("t2b");
      send_bits(16'b1010101, 7, 1'b0, "t2_nov");

      // Enable gaps hold history.
      do_reset("t3");
      send_bits(16'b10, 2, 1'b0, "t3_pre");
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'($urandom_range(1)), 1'b0, '0, 1'b0, 1'b0, "t3_idle");
      send_bits(16'b101, 3, 1'b0, "t3_post");

      // Runtime pattern load discards partial history.
      do_reset("t4");
      send_bits(16'b101, 3, 1'b0, "t4_pre");
      step(1'b1, 1'b1, 1'b1, 5'b11001, 1'b0, 1'b0, "t4_load");
      send_bits(16'b11001, 5, 1'b0, "t4_new");
      send_bits(16'b10101, 5, 1'b0, "t4_old");

      // Asynchronous reset while match is high, and mid-sequence with a custom pattern.
      do_reset("t5a");
      send_bits(16'b10101, 5, 1'b1, "t5_hit");
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("t5_async_match", {31'd0, match}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b1, 5'b00110, 1'b0, 1'b0, "t5_load");
      send_bits(16'b1010, 4, 1'b0, "t5_part");
      do_reset("t5b");
      send_bits(16'b1, 1, 1'b0, "t5_one");
      send_bits(16'b0101, 4, 1'b0, "t5_default");

      // Random traffic against the reference model.
      do_reset("rnd");
      for (int i = 0; i < 500; i++) begin
         logic [PAT_W-1:0] pi;
         pi = ($urandom_range(1) == 1) ? PAT_DEF : PAT_W'($urandom);
         step(($urandom_range(3) != 0), 1'($urandom_range(1)),
              ($urandom_range(39) == 0), pi, 1'($urandom_range(1)),
              ($urandom_range(49) == 0), "rnd");
      end

`ifdef MATCH_CNT_EN
      // Counter saturation, then clear on a hit edge.
      do_reset("t6");
      for (int i = 0; i < 600; i++)
         step(1'b1, 1'((i + 1) % 2), 1'b0, '0, 1'b1, 1'b0, "t6_sat");
      check("t6_sat_val", {24'd0, match_cnt}, 32'd255);
      step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, "t6_clr");
      check("t6_clr_hit", {31'd0, match}, 32'd1);
      check("t6_clr_val", {24'd0, match_cnt}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
